// File: rtl/nanoproc_core.sv
// Accumulator nanoprocessor: ACC plus C/Z flags, 16 opcodes, two-word instructions,
// three cycles per instruction (fetch opcode, fetch operand, execute).
module nanoproc_core #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_write,
  output logic [DW-1:0] out_port,
  output logic          out_valid,
  output logic          instr_done
);

  localparam logic [1:0] FETCH_I = 2'd0;
  localparam logic [1:0] FETCH_A = 2'd1;
  localparam logic [1:0] EXEC    = 2'd2;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_XOR = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SBC = 4'h7;
  localparam logic [3:0] OP_ROL = 4'h8;
  localparam logic [3:0] OP_ROR = 4'h9;
  localparam logic [3:0] OP_LDA = 4'hA;
  localparam logic [3:0] OP_STA = 4'hB;
  localparam logic [3:0] OP_OUT = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_JNC = 4'hE;
  localparam logic [3:0] OP_JNZ = 4'hF;

  localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_PC);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          c_q, c_d;
  logic          z_q, z_d;
  logic [3:0]    ir_q, ir_d;
  logic [AW-1:0] opa_q, opa_d;
  logic [DW-1:0] out_port_q, out_port_d;
  logic          out_valid_q, out_valid_d;

  logic          exec_cycle;
  logic          exec_sta;
  logic          acc_wr;
  logic [DW-1:0] alu_b;
  logic          alu_cin;
  logic [DW:0]   alu_sum;

  // Shared adder: subtraction is ACC + ~M + cin, so C=1 means "no borrow".
  always_comb begin
    alu_b   = mem_rdata;
    alu_cin = 1'b0;
    case (ir_q)
      OP_ADC: alu_cin = c_q;
      OP_SUB: begin
        alu_b   = ~mem_rdata;
        alu_cin = 1'b1;
      end
      OP_SBC: begin
        alu_b   = ~mem_rdata;
        alu_cin = c_q;
      end
      default: ;
    endcase
    alu_sum = {1'b0, acc_q} + {1'b0, alu_b} + {{DW{1'b0}}, alu_cin};
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    c_d         = c_q;
    z_d         = z_q;
    ir_d        = ir_q;
    opa_d       = opa_q;
    out_port_d  = out_port_q;
    out_valid_d = 1'b0;
    mem_addr    = pc_q;
    exec_cycle  = 1'b0;
    exec_sta    = 1'b0;
    acc_wr      = 1'b0;
    case (state_q)
      FETCH_I: begin
        if (run) begin
          ir_d    = mem_rdata[3:0];
          state_d = FETCH_A;
        end
      end
      FETCH_A: begin
        mem_addr = pc_q + AW'(1);
        opa_d    = mem_rdata[AW-1:0];
        pc_d     = pc_q + AW'(2);
        state_d  = EXEC;
      end
      EXEC: begin
        mem_addr   = opa_q;
        exec_cycle = 1'b1;
        state_d    = FETCH_I;
        case (ir_q)
          OP_NOP: ;
          OP_XOR: begin acc_d = acc_q ^ mem_rdata; acc_wr = 1'b1; end
          OP_AND: begin acc_d = acc_q & mem_rdata; acc_wr = 1'b1; end
          OP_OR:  begin acc_d = acc_q | mem_rdata; acc_wr = 1'b1; end
          OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            {c_d, acc_d} = alu_sum;
            acc_wr       = 1'b1;
          end
          OP_ROL: begin {c_d, acc_d} = {acc_q, c_q}; acc_wr = 1'b1; end
          OP_ROR: begin {acc_d, c_d} = {c_q, acc_q}; acc_wr = 1'b1; end
          OP_LDA: begin acc_d = mem_rdata; acc_wr = 1'b1; end
          OP_STA: exec_sta = 1'b1;
          OP_OUT: begin
            out_port_d  = acc_q;
            out_valid_d = 1'b1;
          end
          // Jumps override the PC+2 already committed in FETCH_A.
          OP_JMP: pc_d = opa_q;
          OP_JNC: if (!c_q) pc_d = opa_q;
          OP_JNZ: if (!z_q) pc_d = opa_q;
          default: ;
        endcase
        if (acc_wr) z_d = (acc_d == '0);
      end
      default: state_d = FETCH_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH_I;
      pc_q        <= RESET_ADDR;
      acc_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      ir_q        <= 4'h0;
      opa_q       <= '0;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      z_q         <= z_d;
      ir_q        <= ir_d;
      opa_q       <= opa_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Gating with reset keeps an in-flight STA from reaching the negedge RAM write.
  assign mem_write  = exec_sta & ~reset;
  assign instr_done = exec_cycle & ~reset;
  assign mem_wdata  = acc_q;
  assign out_port   = out_port_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_nanoproc_core.sv
// Directed bench for nanoproc_core: an 8-bit instance driven by a table of ALU vectors
// and hand-written programs, plus a 16-bit/10-bit-address instance for wrap behaviour.
module tb_nanoproc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- 8-bit instance and its RAM ----------------
  logic       rst8 = 1'b1, run8 = 1'b0;
  logic [7:0] ma8, wd8, rd8, op8;
  logic       mw8, ov8, done8;
  logic [7:0] ram8 [256];
  logic       ld8_en = 1'b0;
  logic [7:0] ld8_a = '0, ld8_d = '0;

  nanoproc_core #(.DW(8), .AW(8), .RESET_PC(0)) dut8 (
    .clk(clk), .reset(rst8), .run(run8),
    .mem_addr(ma8), .mem_wdata(wd8), .mem_rdata(rd8), .mem_write(mw8),
    .out_port(op8), .out_valid(ov8), .instr_done(done8)
  );

  always @(negedge clk) begin
    if (ld8_en) ram8[ld8_a] <= ld8_d;
    else if (mw8) ram8[ma8] <= wd8;
    rd8 <= ram8[ma8];
  end

  // ---------------- 16-bit instance and its RAM ----------------
  logic        rst16 = 1'b1, run16 = 1'b1;
  logic [9:0]  ma16;
  logic [15:0] wd16, rd16, op16;
  logic        mw16, ov16, done16;
  logic [15:0] ram16 [1024];
  logic        ld16_en = 1'b0;
  logic [9:0]  ld16_a = '0;
  logic [15:0] ld16_d = '0;

  nanoproc_core #(.DW(16), .AW(10), .RESET_PC(0)) dut16 (
    .clk(clk), .reset(rst16), .run(run16),
    .mem_addr(ma16), .mem_wdata(wd16), .mem_rdata(rd16), .mem_write(mw16),
    .out_port(op16), .out_valid(ov16), .instr_done(done16)
  );

  always @(negedge clk) begin
    if (ld16_en) ram16[ld16_a] <= ld16_d;
    else if (mw16) ram16[ma16] <= wd16;
    rd16 <= ram16[ma16];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic ld8(input logic [7:0] a, input logic [7:0] d);
    ld8_en = 1'b1; ld8_a = a; ld8_d = d;
    @(negedge clk); #1;
    ld8_en = 1'b0;
  endtask

  task automatic ld16(input logic [9:0] a, input logic [15:0] d);
    ld16_en = 1'b1; ld16_a = a; ld16_d = d;
    @(negedge clk); #1;
    ld16_en = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] acc0;
    logic       c0;
    logic [7:0] m;
    logic [7:0] acc_x;
    logic       c_x;
    logic       z_x;
  } vec_t;

  vec_t vecs[16];
  logic [7:0] outs[$];
  int   cnt;
  logic [9:0] exp_addr[13];

  initial begin
    vecs[0]  = '{4'h4, 8'hFF, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1}; // ADD overflow
    vecs[1]  = '{4'h5, 8'h00, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0}; // ADC carry in
    vecs[2]  = '{4'h6, 8'h01, 1'b0, 8'h02, 8'hFF, 1'b0, 1'b0}; // SUB borrow
    vecs[3]  = '{4'h6, 8'h05, 1'b0, 8'h05, 8'h00, 1'b1, 1'b1}; // SUB equal
    vecs[4]  = '{4'h7, 8'h05, 1'b0, 8'h02, 8'h02, 1'b1, 1'b0}; // SBC with borrow in
    vecs[5]  = '{4'h7, 8'h05, 1'b1, 8'h02, 8'h03, 1'b1, 1'b0}; // SBC no borrow in
    vecs[6]  = '{4'h1, 8'hF0, 1'b1, 8'hFF, 8'h0F, 1'b1, 1'b0}; // XOR keeps C
    vecs[7]  = '{4'h2, 8'hF0, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b1}; // AND zero
    vecs[8]  = '{4'h3, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1}; // OR zero
    vecs[9]  = '{4'h8, 8'h81, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0}; // ROL
    vecs[10] = '{4'h9, 8'h02, 1'b1, 8'h00, 8'h81, 1'b0, 1'b0}; // ROR
    vecs[11] = '{4'h9, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1}; // ROR to zero
    vecs[12] = '{4'h5, 8'h7F, 1'b1, 8'h80, 8'h00, 1'b1, 1'b1}; // ADC wrap
    vecs[13] = '{4'hA, 8'h55, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1}; // LDA zero
    vecs[14] = '{4'h0, 8'h00, 1'b1, 8'h33, 8'h00, 1'b1, 1'b1}; // NOP
    vecs[15] = '{4'h4, 8'h12, 1'b1, 8'h34, 8'h46, 1'b0, 1'b0}; // ADD ignores C

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_mem_addr", 32'(ma8), 32'h0);
    chk("rst_mem_write", 32'(mw8), 32'h0);
    chk("rst_out_port", 32'(op8), 32'h0);
    chk("rst_out_valid", 32'(ov8), 32'h0);
    chk("rst_instr_done", 32'(done8), 32'h0);
    chk("rst_wdata_acc", 32'(wd8), 32'h0);
    $display("[TB] reset state checked");

    // ---- table: one ALU op per vector ----
    // prog: LDA [80]; ROR (C<-bit0); LDA [81]; op [82]; JMP 8
    for (int i = 0; i < 16; i++) begin
      rst8 = 1'b1; run8 = 1'b1;
      ld8(8'h00, 8'h0A); ld8(8'h01, 8'h80);
      ld8(8'h02, 8'h09); ld8(8'h03, 8'h00);
      ld8(8'h04, 8'hFA); ld8(8'h05, 8'h81);
      ld8(8'h06, {4'h5, vecs[i].op}); ld8(8'h07, 8'h82);
      ld8(8'h08, 8'h0D); ld8(8'h09, 8'h08);
      ld8(8'h80, {7'b0, vecs[i].c0});
      ld8(8'h81, vecs[i].acc0);
      ld8(8'h82, vecs[i].m);
      @(negedge clk); rst8 = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      $display("[TB] vec %0d op=%h acc0=%h c0=%0d m=%h -> acc=%h c=%0d z=%0d",
               i, vecs[i].op, vecs[i].acc0, vecs[i].c0, vecs[i].m, wd8, dut8.c_q, dut8.z_q);
      chk($sformatf("vec%0d_acc", i), 32'(wd8), 32'(vecs[i].acc_x));
      chk($sformatf("vec%0d_c", i), 32'(dut8.c_q), 32'(vecs[i].c_x));
      chk($sformatf("vec%0d_z", i), 32'(dut8.z_q), 32'(vecs[i].z_x));
    end

    // ---- seq 1: run stall, 3-cycle cadence, LDA/ADD/STA ----
    rst8 = 1'b1; run8 = 1'b0;
    ld8(8'h00, 8'h0A); ld8(8'h01, 8'h20);
    ld8(8'h02, 8'h04); ld8(8'h03, 8'h21);
    ld8(8'h04, 8'h0B); ld8(8'h05, 8'h22);
    ld8(8'h06, 8'h0D); ld8(8'h07, 8'h06);
    ld8(8'h20, 8'h03); ld8(8'h21, 8'h04); ld8(8'h22, 8'h00);
    @(negedge clk); rst8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("stall_addr", 32'(ma8), 32'h0);
      chk("stall_done", 32'(done8), 32'h0);
    end
    @(negedge clk); run8 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      chk($sformatf("cadence_k%0d", k), 32'(done8), (k % 3 == 2) ? 32'h1 : 32'h0);
    end
    repeat (3) @(negedge clk);
    $display("[TB] seq1 RAM[22]=%h c=%0d z=%0d", ram8[8'h22], dut8.c_q, dut8.z_q);
    chk("seq1_ram22", 32'(ram8[8'h22]), 32'h07);
    chk("seq1_c", 32'(dut8.c_q), 32'h0);
    chk("seq1_z", 32'(dut8.z_q), 32'h0);

    // ---- seq 3: count-down loop with OUT and JNZ ----
    rst8 = 1'b1;
    ld8(8'h00, 8'h0A); ld8(8'h01, 8'h30);
    ld8(8'h02, 8'h06); ld8(8'h03, 8'h31);
    ld8(8'h04, 8'h0C); ld8(8'h05, 8'h00);
    ld8(8'h06, 8'h0F); ld8(8'h07, 8'h02);
    ld8(8'h08, 8'h0D); ld8(8'h09, 8'h08);
    ld8(8'h30, 8'h03); ld8(8'h31, 8'h01);
    outs.delete();
    @(negedge clk); rst8 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (ov8) outs.push_back(op8);
    end
    $display("[TB] seq3 out_valid pulses=%0d", outs.size());
    chk("loop_pulses", 32'(outs.size()), 32'h3);
    if (outs.size() == 3) begin
      chk("loop_out0", 32'(outs[0]), 32'h2);
      chk("loop_out1", 32'(outs[1]), 32'h1);
      chk("loop_out2", 32'(outs[2]), 32'h0);
    end
    chk("loop_acc_end", 32'(wd8), 32'h0);

    // ---- seq 5: reset during EXEC of STA ----
    rst8 = 1'b1;
    ld8(8'h00, 8'h0A); ld8(8'h01, 8'h20);
    ld8(8'h02, 8'h0C); ld8(8'h03, 8'h00);
    ld8(8'h04, 8'h0B); ld8(8'h05, 8'h22);
    ld8(8'h06, 8'h0D); ld8(8'h07, 8'h06);
    ld8(8'h20, 8'h5A); ld8(8'h22, 8'hEE);
    @(negedge clk); rst8 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30 && cnt < 3; k++) begin
      @(posedge clk); #1;
      if (done8) cnt++;
    end
    chk("rst_sta_reached", 32'(cnt), 32'h3);
    if (cnt == 3) begin
      chk("sta_write_pending", 32'(mw8), 32'h1);
      chk("sta_out_before", 32'(op8), 32'h5A);
      rst8 = 1'b1; #1;
      chk("sta_write_gated", 32'(mw8), 32'h0);
      @(posedge clk); #1;
      chk("post_rst_addr", 32'(ma8), 32'h0);
      chk("post_rst_out", 32'(op8), 32'h0);
      chk("post_rst_valid", 32'(ov8), 32'h0);
      chk("post_rst_done", 32'(done8), 32'h0);
      chk("post_rst_write", 32'(mw8), 32'h0);
      chk("post_rst_acc", 32'(wd8), 32'h0);
      repeat (2) @(negedge clk);
      chk("sta_not_written", 32'(ram8[8'h22]), 32'hEE);
    end
    $display("[TB] seq5 reset-in-STA RAM[22]=%h", ram8[8'h22]);

    // ---- seq 6: DW=16 AW=10, carry out of bit 15 and address wrap ----
    ld16(10'h000, 16'h000A); ld16(10'h001, 16'h0100);
    ld16(10'h002, 16'h0004); ld16(10'h003, 16'h0101);
    ld16(10'h004, 16'h000D); ld16(10'h005, 16'h03FF);
    ld16(10'h3FF, 16'h000C);
    ld16(10'h100, 16'hFFFF); ld16(10'h101, 16'h0001);
    exp_addr = '{10'h000, 10'h001, 10'h100, 10'h002, 10'h003, 10'h101,
                 10'h004, 10'h005, 10'h3FF, 10'h3FF, 10'h000, 10'h00A, 10'h001};
    @(negedge clk); rst16 = 1'b0; #1;
    for (int s = 0; s < 13; s++) begin
      if (s > 0) begin
        @(negedge clk); #1;
      end
      chk($sformatf("w16_addr_s%0d", s), 32'(ma16), 32'(exp_addr[s]));
      if (s == 6) begin
        chk("w16_acc", 32'(wd16), 32'h0);
        chk("w16_c", 32'(dut16.c_q), 32'h1);
        chk("w16_z", 32'(dut16.z_q), 32'h1);
      end
      if (s == 12) chk("w16_out_valid", 32'(ov16), 32'h1);
    end
    $display("[TB] seq6 wide core wrap sequence checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
